// File: rtl/rr_put_arbiter.sv
`default_nettype none
// ============================================================================
// rr_put_arbiter : round-robin, burst-locking arbiter in front of a FIFO put port
// Revision 1.0
// ============================================================================
module rr_put_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [ID_W-1:0]               out_id,
   output logic                          busy
);

   localparam int              CNT_W       = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(MAX_BURST - 1);
   localparam logic [ID_W-1:0]  c_last_req  = ID_W'(NUM_REQ - 1);
   localparam logic [ID_W:0]    c_num_req   = (ID_W+1)'(NUM_REQ);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [ID_W-1:0]  grant_q, grant_d;
   logic [ID_W-1:0]  last_grant_q, last_grant_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

   logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];
   logic                  w_found;
   logic [ID_W-1:0]       w_pick;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign w_data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // Scan last_grant+1 .. last_grant+NUM_REQ so the previous owner comes last.
   always_comb begin : arb_scan
      logic [ID_W:0] cand;
      cand    = '0;
      w_found = 1'b0;
      w_pick  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, last_grant_q} + (ID_W+1)'(k);
         if (cand >= c_num_req) begin
            cand = cand - c_num_req;
         end
         if (!w_found && req_valid[cand[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_pick  = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      out_valid    = 1'b0;
      out_data     = '0;
      req_ready    = '0;
      busy         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_found) begin
               grant_d    = w_pick;
               beat_cnt_d = '0;
               state_d    = S_GRANT;
            end
         end
         S_GRANT: begin
            busy     = 1'b1;
            out_data = w_data_arr[grant_q];
            // Handshake is suppressed while reset is asserted so no beat slips through.
            if (!reset) begin
               out_valid          = req_valid[grant_q];
               req_ready[grant_q] = out_ready;
            end
            if (req_valid[grant_q] && out_ready) begin
               if (req_last[grant_q] || (beat_cnt_q == c_last_beat)) begin
                  state_d      = S_IDLE;
                  last_grant_d = grant_q;
                  beat_cnt_d   = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign out_id = grant_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         last_grant_q <= c_last_req;
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rr_put_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rr_put_arbiter : checks MAX_BURST=4 and MAX_BURST=1 instances against a burst-level model
// Revision 1.0
// ============================================================================
module tb_rr_put_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid, req_last;
   logic [31:0] req_data;
   logic        out_ready;

   logic       ov0, ov1, bz0, bz1;
   logic [3:0] rr0, rr1;
   logic [7:0] od0, od1;
   logic [1:0] oid0, oid1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rr_put_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut4 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr0),
      .req_data(req_data), .req_last(req_last), .out_valid(ov0),
      .out_ready(out_ready), .out_data(od0), .out_id(oid0), .busy(bz0)
   );

   rr_put_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr1),
      .req_data(req_data), .req_last(req_last), .out_valid(ov1),
      .out_ready(out_ready), .out_data(od1), .out_id(oid1), .busy(bz1)
   );

   // Burst-level model: owner, beats taken so far, and who was served last.
   int m_busy  [2];
   int m_own   [2];
   int m_last  [2];
   int m_beats [2];
   int mb      [2] = '{4, 1};
   bit known = 1'b0;

   typedef struct {
      logic        rst;
      logic [3:0]  v;
      logic [3:0]  l;
      logic [31:0] d;
      logic        rdy;
      logic        ev;
      logic [3:0]  er;
      logic [7:0]  ed;
      logic [1:0]  eid;
      logic        eb;
   } vec_t;

   vec_t tbl [7];

   function automatic bit has(input logic [3:0] v, input int i);
      return ((v >> i) & 4'd1) != 4'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      #1;
      if (known) begin
         for (int k = 0; k < 2; k++) begin
            logic       ev;
            logic [3:0] er;
            logic [7:0] ed;
            ev = 1'b0;
            er = '0;
            ed = '0;
            if (m_busy[k] != 0) begin
               ed = 8'(req_data >> (m_own[k] * 8));
               if (!reset) begin
                  ev = has(req_valid, m_own[k]);
                  er = 4'(out_ready) << m_own[k];
               end
            end
            chk($sformatf("%s.u%0d.out_valid", tag, k), 32'(k == 0 ? ov0 : ov1), 32'(ev));
            chk($sformatf("%s.u%0d.req_ready", tag, k), 32'(k == 0 ? rr0 : rr1), 32'(er));
            chk($sformatf("%s.u%0d.out_data", tag, k), 32'(k == 0 ? od0 : od1), 32'(ed));
            chk($sformatf("%s.u%0d.out_id", tag, k), 32'(k == 0 ? oid0 : oid1), 32'(m_own[k]));
            chk($sformatf("%s.u%0d.busy", tag, k), 32'(k == 0 ? bz0 : bz1), 32'(m_busy[k] != 0));
         end
      end
   endtask

   task automatic tick();
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_busy[k]  = 0;
            m_own[k]   = 0;
            m_last[k]  = 3;
            m_beats[k] = 0;
         end else if (m_busy[k] == 0) begin
            for (int s = 1; s <= 4; s++) begin
               int c;
               c = (m_last[k] + s) % 4;
               if (m_busy[k] == 0 && has(req_valid, c)) begin
                  m_busy[k]  = 1;
                  m_own[k]   = c;
                  m_beats[k] = 0;
               end
            end
         end else if (has(req_valid, m_own[k]) && out_ready) begin
            m_beats[k]++;
            if (has(req_last, m_own[k]) || m_beats[k] == mb[k]) begin
               m_busy[k] = 0;
               m_last[k] = m_own[k];
            end
         end
      end
      if (reset) known = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag);
      check_model(tag);
      tick();
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      out_ready = 1'b1;
      cyc("rst");
      reset = 1'b0;
   endtask

   initial begin
      int nb;
      tbl[0] = '{1'b0, 4'b0010, 4'b0010, 32'h0000_A500, 1'b1, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0};
      tbl[1] = '{1'b0, 4'b0010, 4'b0010, 32'h0000_A500, 1'b1, 1'b1, 4'b0010, 8'hA5, 2'd1, 1'b1};
      tbl[2] = '{1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 8'h00, 2'd1, 1'b0};
      tbl[3] = '{1'b0, 4'b0100, 4'b0000, 32'h0033_0000, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd1, 1'b0};
      tbl[4] = '{1'b0, 4'b0100, 4'b0000, 32'h0033_0000, 1'b0, 1'b1, 4'b0000, 8'h33, 2'd2, 1'b1};
      tbl[5] = '{1'b0, 4'b0100, 4'b0100, 32'h0033_0000, 1'b1, 1'b1, 4'b0100, 8'h33, 2'd2, 1'b1};
      tbl[6] = '{1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 8'h00, 2'd2, 1'b0};

      do_reset();
      for (int i = 0; i < 7; i++) begin
         reset     = tbl[i].rst;
         req_valid = tbl[i].v;
         req_last  = tbl[i].l;
         req_data  = tbl[i].d;
         out_ready = tbl[i].rdy;
         check_model("tbl");
         chk($sformatf("tbl%0d.out_valid", i), 32'(ov0), 32'(tbl[i].ev));
         chk($sformatf("tbl%0d.req_ready", i), 32'(rr0), 32'(tbl[i].er));
         chk($sformatf("tbl%0d.out_data", i), 32'(od0), 32'(tbl[i].ed));
         chk($sformatf("tbl%0d.out_id", i), 32'(oid0), 32'(tbl[i].eid));
         chk($sformatf("tbl%0d.busy", i), 32'(bz0), 32'(tbl[i].eb));
         tick();
      end

      // All four streaming: 4-beat bursts rotating 0,1,2,3,0 with one idle cycle between.
      do_reset();
      req_valid = 4'hF;
      req_last  = '0;
      out_ready = 1'b1;
      nb = 0;
      for (int c = 0; c < 25; c++) begin
         req_data = $urandom;
         check_model("stream");
         if (bz0 && ov0 && out_ready) begin
            chk($sformatf("stream.beat%0d.id", nb), 32'(oid0), 32'((nb / 4) % 4));
            chk($sformatf("stream.beat%0d.cycle", nb), 32'(c), 32'(1 + nb + nb / 4));
            nb++;
         end
         tick();
      end
      chk("stream.beats", 32'(nb), 32'd20);

      // Backpressure on requester 2 for five cycles, then the full burst still follows.
      do_reset();
      req_valid = 4'b0100;
      req_data  = 32'h005A_0000;
      cyc("bp.arb");
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         check_model("bp.stall");
         chk("bp.stall.out_valid", 32'(ov0), 32'd1);
         chk("bp.stall.req_ready", 32'(rr0), 32'd0);
         chk("bp.stall.out_id", 32'(oid0), 32'd2);
         tick();
      end
      out_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         check_model("bp.run");
         chk("bp.run.busy", 32'(bz0), 32'd1);
         chk("bp.run.req_ready", 32'(rr0), 32'b0100);
         tick();
      end
      check_model("bp.end");
      chk("bp.end.busy", 32'(bz0), 32'd0);
      tick();

      // Requester 3 ends its burst early; alt=0 has 0 waiting, alt=1 has only 3 again.
      for (int alt = 0; alt < 2; alt++) begin
         do_reset();
         req_valid = 4'b1000;
         cyc("r3.arb");
         req_valid = 4'b1001;
         check_model("r3.b1");
         chk("r3.b1.out_id", 32'(oid0), 32'd3);
         tick();
         req_last = 4'b1000;
         check_model("r3.b2");
         chk("r3.b2.req_ready", 32'(rr0), 32'b1000);
         tick();
         req_last  = '0;
         req_valid = (alt != 0) ? 4'b1000 : 4'b1001;
         check_model("r3.idle");
         chk("r3.idle.busy", 32'(bz0), 32'd0);
         tick();
         check_model("r3.next");
         chk($sformatf("r3.next%0d.out_id", alt), 32'(oid0), (alt != 0) ? 32'd3 : 32'd0);
         chk("r3.next.busy", 32'(bz0), 32'd1);
         tick();
      end

      // Reset in the middle of a burst from requester 0.
      do_reset();
      req_valid = 4'b0011;
      cyc("mid.arb");
      cyc("mid.b1");
      cyc("mid.b2");
      reset = 1'b1;
      check_model("mid.rst");
      chk("mid.rst.out_valid", 32'(ov0), 32'd0);
      tick();
      reset = 1'b0;
      check_model("mid.after");
      chk("mid.after.busy", 32'(bz0), 32'd0);
      chk("mid.after.req_ready", 32'(rr0), 32'd0);
      tick();
      check_model("mid.regrant");
      chk("mid.regrant.out_id", 32'(oid0), 32'd0);
      chk("mid.regrant.busy", 32'(bz0), 32'd1);
      tick();

      // Single-beat bursts alternate between requesters 0 and 2.
      do_reset();
      req_valid = 4'b0101;
      for (int c = 0; c < 8; c++) begin
         check_model("mb1");
         chk($sformatf("mb1.c%0d.out_valid", c), 32'(ov1), 32'(c % 2));
         if (c % 2 == 1) begin
            chk($sformatf("mb1.c%0d.out_id", c), 32'(oid1), ((c / 2) % 2 == 1) ? 32'd2 : 32'd0);
         end
         tick();
      end

      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 63) == 0);
         req_valid = 4'($urandom);
         req_last  = 4'($urandom) & 4'($urandom);
         req_data  = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         cyc("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
